ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 29 ++
 rtl/ifetch_inst_fifo.sv | 65 ++++++
 rtl/ifetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the fetch front end: next-PC operation codes and
// fetch-unit FSM state encodings, plus small address helpers.
package ifetch_pkg;

    // Next-PC unit operation codes
    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JAL    = 2'd2,
        NPC_JALR   = 2'd3
    } npc_op_e;

    // Fetch-unit FSM states
    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_DROP = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_PC_STEP   = 32'd4;
    localparam logic [31:0] IFU_WORD_MASK = 32'hFFFF_FFFC;

    // Force an address onto a word boundary
    function automatic logic [31:0] ifu_align(input logic [31:0] addr);
        return addr & IFU_WORD_MASK;
    endfunction

endpackage

// File: rtl/ifetch_inst_fifo.sv
// Instruction buffer: power-of-two deep FIFO with synchronous flush.
// Flush has priority over push and pop issued in the same cycle.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        end
    end

    // Storage write; contents are only observed through a valid head entry
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues one word request at a time, buffers
// returned words with their PC, and honours redirects by flushing the
// buffer and discarding any response already in flight.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Redirect,
    input  logic [31:0] Npc,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Inst,
    output logic [31:0] InstPc
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    ifu_state_e     r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic           r_imem_req;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_cnt_next;
    logic           w_room_next;
    logic           w_fire;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;
    logic [63:0]    w_head;

    assign w_valid = (w_count != {CW{1'b0}});
    assign w_pop   = w_valid && InstReady;
    assign w_fire  = r_imem_req && ImemGnt;
    // A response arriving together with a redirect belongs to the old path
    assign w_push  = (r_state == IFU_WAIT) && ImemRvalid && !Redirect;

    // Buffer occupancy after this edge; drives the registered request flag
    always_comb begin
        w_cnt_next = w_count;
        if (Redirect) begin
            w_cnt_next = {CW{1'b0}};
        end else begin
            w_cnt_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        end
    end

    assign w_room_next = (w_cnt_next < DEPTH_C);

    // Fetch FSM, PC and registered request strobe
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state    <= IFU_IDLE;
            r_imem_req <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'h0000_0000;
        end else begin
            case (r_state)
                IFU_IDLE: begin
                    r_state    <= IFU_REQ;
                    r_imem_req <= w_room_next;
                end
                IFU_REQ: begin
                    if (w_fire) begin
                        r_state    <= Redirect ? IFU_DROP : IFU_WAIT;
                        r_req_pc   <= r_pc;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= IFU_REQ;
                        r_imem_req <= w_room_next;
                    end
                end
                IFU_WAIT: begin
                    if (ImemRvalid) begin
                        r_state    <= IFU_REQ;
                        r_imem_req <= w_room_next;
                    end else if (Redirect) begin
                        r_state    <= IFU_DROP;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= IFU_WAIT;
                        r_imem_req <= 1'b0;
                    end
                end
                IFU_DROP: begin
                    if (ImemRvalid) begin
                        r_state    <= IFU_REQ;
                        r_imem_req <= w_room_next;
                    end else begin
                        r_state    <= IFU_DROP;
                        r_imem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IFU_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase

            if (Redirect) begin
                r_pc <= ifu_align(Npc);
            end else if (w_fire) begin
                r_pc <= r_pc + IFU_PC_STEP;
            end else begin
                r_pc <= r_pc;
            end
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64),
        .CW    (CW)
    ) u_inst_fifo (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_flush (Redirect),
        .i_push  (w_push),
        .i_wdata ({ImemRdata, r_req_pc}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign ImemReq   = r_imem_req;
    assign ImemAddr  = r_pc;
    assign InstValid = w_valid;
    assign Inst      = w_valid ? w_head[63:32] : 32'h0000_0000;
    assign InstPc    = w_valid ? w_head[31:0]  : 32'h0000_0000;

endmodule
